// File: rtl/keycode_event_ctrl.sv
// Keycode event controller.
// Watches a 32-bit word of four keycode byte slots. When the word changes it
// scans the previous word against the new one, one slot per cycle: release
// events first, then press events. Events go into a small FIFO for a
// downstream consumer. A sticky overflow flag records any dropped event.
module keycode_event_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   keycode,
  input  logic                          ev_ready,
  input  logic                          clr_ovf,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_press,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REL  = 2'd1,
    PRS  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  s_reg, s_next;
  logic [31:0] old_snap_reg, old_snap_next;
  logic [31:0] new_snap_reg, new_snap_next;

  // Slot evaluation signals
  logic [31:0] scan_word;
  logic [31:0] other_word;
  logic [7:0]  slot_code;
  logic        in_other;
  logic        dup_lower;
  logic        push;
  logic        push_press;

  // FIFO storage and bookkeeping
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic          overflow_reg;
  logic [8:0]    head;

  // Scan FSM registers: state, slot index and both snapshots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      s_reg        <= 2'd0;
      old_snap_reg <= 32'h0;
      new_snap_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      old_snap_reg <= old_snap_next;
      new_snap_reg <= new_snap_next;
    end
  end

  // Next-state logic: detect a change in IDLE, then walk 4 REL and 4 PRS slots
  always_comb begin
    state_next    = state_reg;
    s_next        = s_reg;
    old_snap_next = old_snap_reg;
    new_snap_next = new_snap_reg;
    case (state_reg)
      IDLE: begin
        if (keycode != old_snap_reg) begin
          new_snap_next = keycode;
          s_next        = 2'd0;
          state_next    = REL;
        end
      end
      REL: begin
        s_next = s_reg + 2'd1;
        if (s_reg == 2'd3) begin
          state_next = PRS;
        end
      end
      PRS: begin
        s_next = s_reg + 2'd1;
        if (s_reg == 2'd3) begin
          state_next    = IDLE;
          old_snap_next = new_snap_reg;
        end
      end
      default: begin
        state_next = IDLE;
        s_next     = 2'd0;
      end
    endcase
  end

  // Slot test: code in the scanned word must be nonzero, missing from the
  // other word, and the first occurrence of that code within its own word
  always_comb begin
    scan_word  = (state_reg == PRS) ? new_snap_reg : old_snap_reg;
    other_word = (state_reg == PRS) ? old_snap_reg : new_snap_reg;
    slot_code  = scan_word[{s_reg, 3'b000} +: 8];
    in_other   = 1'b0;
    dup_lower  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (other_word[8*k +: 8] == slot_code) begin
        in_other = 1'b1;
      end
      if ((k < int'(s_reg)) && (scan_word[8*k +: 8] == slot_code)) begin
        dup_lower = 1'b1;
      end
    end
    push       = ((state_reg == REL) || (state_reg == PRS)) &&
                 (slot_code != 8'h00) && !in_other && !dup_lower;
    push_press = (state_reg == PRS);
  end

  // FIFO control: a push into a full FIFO only fits if the head leaves too
  always_comb begin
    full  = (count_reg == FULL_COUNT);
    pop   = ev_valid && ev_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  // Event storage; entries are {press, code}
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {push_press, slot_code};
    end
  end

  // Pointers, occupancy and sticky overflow (a drop beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (wr_en && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !wr_en) begin
        count_reg <= count_reg - 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Head presentation; outputs read as zero while the FIFO is empty
  always_comb begin
    head       = mem[rd_ptr_reg];
    ev_valid   = (count_reg != '0);
    ev_code    = ev_valid ? head[7:0] : 8'h00;
    ev_press   = ev_valid ? head[8] : 1'b0;
    fifo_count = count_reg;
    overflow   = overflow_reg;
    busy       = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Self-checking bench for keycode_event_ctrl: directed scenarios plus a
// randomized sequence scored against a set-difference model of key events.
module tb_keycode_event_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] keycode;
  logic        ev_ready;
  logic        clr_ovf;
  logic        ev_valid;
  logic [7:0]  ev_code;
  logic        ev_press;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  keycode_event_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .ev_ready   (ev_ready),
    .clr_ovf    (clr_ovf),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_press   (ev_press),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  // First slot holding code c in word w, or -1 if absent
  function automatic int first_index(input logic [31:0] w, input logic [7:0] c);
    for (int i = 0; i < 4; i++) begin
      if (w[8*i +: 8] == c) return i;
    end
    return -1;
  endfunction

  // Expected events for a word change: codes that disappeared (releases)
  // then codes that appeared (presses), each once, in first-slot order
  function automatic void model_scan(input logic [31:0] o, input logic [31:0] n);
    logic [7:0] c;
    for (int i = 0; i < 4; i++) begin
      c = o[8*i +: 8];
      if (c != 8'h00 && first_index(n, c) < 0 && first_index(o, c) == i)
        exp_q.push_back({1'b0, c});
    end
    for (int i = 0; i < 4; i++) begin
      c = n[8*i +: 8];
      if (c != 8'h00 && first_index(o, c) < 0 && first_index(n, c) == i)
        exp_q.push_back({1'b1, c});
    end
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    keycode  = 32'h0;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;
    got_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Step cycles; mode 0: ready low, 1: ready high, 2: random. Records pops.
  task automatic collect(input int ncyc, input int mode);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      ev_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      if (ev_valid && ev_ready) got_q.push_back({ev_press, ev_code});
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    keycode  = 32'hDEADBEEF;
    ev_ready = 1'b1;
    clr_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %0b exp 0", ev_valid); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL reset_ev_code got %h exp 00", ev_code); end
    checks++; if (ev_press !== 1'b0) begin errors++; $display("FAIL reset_ev_press got %0b exp 0", ev_press); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int busy_cnt;
    int first_valid;
    do_reset();
    busy_cnt    = 0;
    first_valid = -1;
    keycode     = 32'h00000004;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ev_ready = 1'b1;
      if (busy) busy_cnt++;
      if (ev_valid && first_valid < 0) first_valid = k;
      if (ev_valid) got_q.push_back({ev_press, ev_code});
    end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL single_busy_cycles got %0d exp 8", busy_cnt); end
    checks++; if (first_valid != 6) begin errors++; $display("FAIL single_first_valid got %0d exp 6", first_valid); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h104) begin
      errors++;
      $display("FAIL single_event got n=%0d first=%h exp n=1 first=104", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
    end
    $display("test_single_press done events=%0d", got_q.size());
  endtask

  task automatic test_swap();
    do_reset();
    keycode = 32'h00001A04;
    collect(12, 1);
    got_q.delete();
    keycode = 32'h0000161A;
    collect(12, 1);
    model_scan(32'h00001A04, 32'h0000161A);
    checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL swap_model_size got %0d exp 2", exp_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL swap_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL swap_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (got_q.size() > 0 && got_q[0] !== 9'h004) begin errors++; $display("FAIL swap_first got %h exp 004", got_q[0]); end
    $display("test_swap done events=%0d", got_q.size());
  endtask

  task automatic test_duplicates();
    do_reset();
    keycode = 32'h04040404;
    collect(14, 1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h104) begin
      errors++;
      $display("FAIL dup_event got n=%0d first=%h exp n=1 first=104", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
    end
    $display("test_duplicates done events=%0d", got_q.size());
  endtask

  task automatic test_overflow();
    do_reset();
    keycode = 32'h04030201;
    collect(12, 0);
    keycode = 32'h08070605;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      clr_ovf = (k <= 8);  // clear held through the final drop: the drop must win
    end
    clr_ovf = 1'b0;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    collect(12, 1);
    model_scan(32'h0, 32'h04030201);
    model_scan(32'h04030201, 32'h08070605);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_drain_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
    $display("test_overflow done drained=%0d", got_q.size());
  endtask

  task automatic test_full_push_pop();
    do_reset();
    keycode = 32'h04030201;
    collect(12, 0);
    keycode = 32'h00000000;
    collect(12, 0);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fpp_prefill got %0d exp 8", fifo_count); end
    keycode = 32'h00000009;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ev_ready = (k == 5);
      if (k == 5) begin
        checks++;
        if ({ev_valid, ev_press, ev_code} !== 10'h301) begin
          errors++; $display("FAIL fpp_head got v=%0b p=%0b c=%h exp v=1 p=1 c=01", ev_valid, ev_press, ev_code);
        end
      end
      if (k == 6) begin
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d exp 8", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %0b exp 0", overflow); end
      end
    end
    collect(14, 1);
    model_scan(32'h0, 32'h04030201);
    model_scan(32'h04030201, 32'h0);
    model_scan(32'h0, 32'h00000009);
    void'(exp_q.pop_front());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fpp_drain_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    $display("test_full_push_pop done drained=%0d", got_q.size());
  endtask

  task automatic test_mid_scan();
    do_reset();
    keycode = 32'h00000004;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      ev_ready = 1'b1;
      if (k == 3) keycode = 32'h00000005;
      if (ev_valid) got_q.push_back({ev_press, ev_code});
      if (k == 9) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got busy=%0b exp 0", busy); end
      end
      if (k == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rescan got busy=%0b exp 1", busy); end
      end
    end
    model_scan(32'h0, 32'h00000004);
    model_scan(32'h00000004, 32'h00000005);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    $display("test_mid_scan done events=%0d", got_q.size());
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    keycode = 32'h00000201;
    collect(12, 0);
    keycode = 32'h00000029;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rms_ev_valid got %0b exp 0", ev_valid); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL rms_ev_code got %h exp 00", ev_code); end
    checks++; if (ev_press !== 1'b0) begin errors++; $display("FAIL rms_ev_press got %0b exp 0", ev_press); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rms_count got %0d exp 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy got %0b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rms_overflow got %0b exp 0", overflow); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    collect(14, 1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 9'h129) begin
      errors++;
      $display("FAIL rms_event got n=%0d first=%h exp n=1 first=129", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
    end
    $display("test_reset_mid_scan done events=%0d", got_q.size());
  endtask

  task automatic test_random();
    logic [31:0] old_w;
    logic [31:0] new_w;
    int w;
    do_reset();
    old_w = 32'h0;
    for (int it = 0; it < 40; it++) begin
      for (int sl = 0; sl < 4; sl++) new_w[8*sl +: 8] = 8'($urandom_range(0, 6));
      keycode = new_w;
      model_scan(old_w, new_w);
      old_w = new_w;
      collect(12, 2);
      for (w = 0; w < 20; w++) begin
        @(negedge clk);
        ev_ready = 1'b1;
        if (!ev_valid) break;
        got_q.push_back({ev_press, ev_code});
      end
      if (w == 20) begin
        checks++; errors++;
        $display("FAIL rand_drain_timeout got still_valid exp empty at iter %0d", it);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %0b exp 0", overflow); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    $display("test_random done events=%0d", got_q.size());
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_swap();
    test_duplicates();
    test_overflow();
    test_full_push_pop();
    test_mid_scan();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_event_ctrl.md
KEYCODE_EVENT_CTRL -- requirements
Module: keycode_event_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, event FIFO depth in entries (power of 2, >= 2).
REQ-002 Port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: keycode  in  32  live keycode word from the keycode PIO; 4 byte slots, slot i = bits [8i+7:8i]; 0x00 = empty slot.
REQ-005 Port: ev_ready  in  1  consumer accepts the event at the FIFO head this cycle.
REQ-006 Port: clr_ovf  in  1  single-cycle pulse; clears the overflow flag.
REQ-007 Port: ev_valid  out  1  FIFO non-empty; head event presented.
REQ-008 Port: ev_code  out  8  key code of the head event.
REQ-009 Port: ev_press  out  1  head event type: 1 = press, 0 = release.
REQ-010 Port: fifo_count  out  log2(FIFO_DEPTH)+1  current number of FIFO entries.
REQ-011 Port: overflow  out  1  sticky flag: at least one event was dropped.
REQ-012 Port: busy  out  1  FSM not in IDLE.

Function
REQ-013 Block SHALL hold two 32-bit registers: old_snap (last fully scanned word) and new_snap (word under scan).
REQ-014 FSM SHALL have states IDLE, REL, PRS; a 2-bit slot index s selects the slot in REL/PRS.
REQ-015 IDLE: when keycode != old_snap, load new_snap <= keycode and s <= 0, go to REL; otherwise stay in IDLE.
REQ-016 REL, slot s: if old_snap slot s is nonzero, absent from all 4 slots of new_snap, and not equal to any old_snap slot < s, push {code, press=0}.
REQ-017 PRS, slot s: if new_snap slot s is nonzero, absent from all 4 slots of old_snap, and not equal to any new_snap slot < s, push {code, press=1}.
REQ-018 Each REL/PRS slot SHALL take exactly one cycle; REL s=3 -> PRS s=0; PRS s=3 -> IDLE with old_snap <= new_snap on the same edge.
REQ-019 Latency: a change first seen in IDLE at edge N gives REL slots on cycles N+1..N+4, PRS slots on N+5..N+8, and IDLE again at N+9; a pushed event is visible on ev_valid the cycle after its slot.
REQ-020 keycode changes during a scan SHALL NOT affect the scan in progress; IDLE re-compares against the updated old_snap and starts a new scan if they differ.
REQ-021 Events SHALL leave the FIFO in push order; a pop occurs when ev_valid && ev_ready.
REQ-022 FIFO full and a push with no pop in the same cycle: drop the event and set overflow <= 1; FIFO contents stay unchanged.
REQ-023 FIFO full with push and pop in the same cycle: accept both; fifo_count stays at FIFO_DEPTH; overflow is unchanged.
REQ-024 FIFO empty: ev_ready is ignored and fifo_count stays 0; there is no bypass, so a push into an empty FIFO is visible one cycle later.
REQ-025 clr_ovf clears overflow; if a drop occurs in the same cycle, the set wins.
REQ-026 ev_code and ev_press SHALL hold stable while ev_valid=1 and ev_ready=0.

Reset
REQ-027 reset_n low SHALL asynchronously force: state=IDLE, s=0, old_snap=0, new_snap=0, FIFO empty, fifo_count=0, ev_valid=0, ev_code=0, ev_press=0, overflow=0, busy=0.
REQ-028 Reset during a scan SHALL discard the scan and all queued events; after release, a nonzero keycode is rescanned against old_snap=0.

Verification
REQ-029 Single press: keycode 0x00000000 -> 0x00000004 with ev_ready=1 -> exactly one event {0x04, press}; busy high for 8 cycles; first ev_valid 6 cycles after detection (PRS slot 0 on N+5).
REQ-030 Swap: old word 0x00001A04, new word 0x0000161A -> events in order {0x04, release}, {0x16, press}; no event for 0x1A.
REQ-031 Duplicate slots: new word 0x04040404 from 0 -> exactly one {0x04, press}.
REQ-032 Overflow: ev_ready=0, FIFO_DEPTH=8; word 0 -> 0x04030201, then -> 0x08070605 -> 8 events queued and 4 press events dropped; overflow=1 and fifo_count=8; a clr_ovf pulse clears overflow.
REQ-033 Mid-scan change: word changes at N+3 of a scan -> first scan completes unaltered, then a second scan starts at IDLE+1 with events relative to the first new word.
REQ-034 Reset mid-scan: assert reset_n low at REL slot 2 -> all outputs return to reset values immediately; after release, keycode 0x00000029 -> one {0x29, press}.
